// File: rtl/bpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bpu_pkg
//  Purpose  : Shared defaults, scheduler state encoding and the update record
//             layout for the branch-predictor write-side scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package bpu_pkg;

    localparam int BPU_PC_W  = 11;
    localparam int BPU_IDX_W = 5;

    typedef enum logic [0:0] {
        BPU_INIT = 1'b0,
        BPU_RUN  = 1'b1
    } bpu_state_e;

    typedef struct packed {
        logic [BPU_IDX_W-1:0] index;
        logic                 taken;
        logic [BPU_PC_W-1:0]  target;
    } bpu_upd_t;

endpackage
`default_nettype wire

// File: rtl/bpu_upd_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bpu_upd_fifo
//  Purpose  : DEPTH-entry in-order queue of update records. Two write ports
//             (push_b only meaningful together with push_a, written behind
//             it), one read port exposing the head, occupancy count and a
//             synchronous clear that wins over any push/pop.
//  Revision : 1.0 - initial release
// ============================================================================
module bpu_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push_a,
    input  logic [WIDTH-1:0]         data_a,
    input  logic                     push_b,
    input  logic [WIDTH-1:0]         data_b,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_ptr_b;
    logic [CNT_W-1:0] w_count_next;

    // Second write lands one slot behind the first; power-of-two depth wraps naturally.
    assign w_wr_ptr_b   = r_wr_ptr + PTR_W'(1);
    assign w_count_next = r_count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    assign head         = r_mem[r_rd_ptr];
    assign count        = r_count;

    // Record storage; no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (!clear && push_a) begin
            r_mem[r_wr_ptr] <= data_a;
        end
        if (!clear && push_b) begin
            r_mem[w_wr_ptr_b] <= data_b;
        end
    end

    // Pointer and occupancy bookkeeping, cleared asynchronously or on request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_b) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(2);
            end else if (push_a) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bpu_update_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bpu_update_scheduler
//  Purpose  : Single write port sequencer for the BHT/BTB. Sweeps every entry
//             to its initial value after reset / init_req, then queues up to
//             two resolved branches per cycle and issues one per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module bpu_update_scheduler
    import bpu_pkg::*;
#(
    parameter int PC_W  = BPU_PC_W,
    parameter int IDX_W = BPU_IDX_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_req,
    input  logic             br_valid1,
    input  logic             br_valid2,
    input  logic [PC_W-1:0]  br_pc1,
    input  logic [PC_W-1:0]  br_pc2,
    input  logic             br_taken1,
    input  logic             br_taken2,
    input  logic [PC_W-1:0]  br_target1,
    input  logic [PC_W-1:0]  br_target2,
    output logic             in_ready,
    output logic             init_done,
    output logic             upd_valid,
    output logic             upd_init,
    output logic [IDX_W-1:0] upd_index,
    output logic             upd_taken,
    output logic [PC_W-1:0]  upd_target
);

    localparam int               REC_W        = IDX_W + 1 + PC_W;
    localparam int               CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [0:0]       c_ST_INIT    = BPU_INIT;
    localparam logic [0:0]       c_ST_RUN     = BPU_RUN;
    localparam logic [IDX_W-1:0] c_SWEEP_LAST = '1;
    localparam logic [CNT_W-1:0] c_READY_MAX  = CNT_W'(DEPTH - 2);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_sweep;
    logic [CNT_W-1:0] w_count;
    logic [REC_W-1:0] w_rec1;
    logic [REC_W-1:0] w_rec2;
    logic [REC_W-1:0] w_rec_first;
    logic [REC_W-1:0] w_head;
    logic             w_run;
    logic             w_accept;
    logic             w_push_a;
    logic             w_push_b;
    logic             w_pop;
    logic             w_pc_hi_unused;

    // Upper PC bits only matter to the frontend; the table index is the low slice.
    assign w_pc_hi_unused = ^{br_pc1[PC_W-1:IDX_W], br_pc2[PC_W-1:IDX_W]};

    assign w_run     = (r_state == c_ST_RUN);
    assign init_done = w_run;
    // Room for a full pair is required, so a lone slot never sneaks past a held pair.
    assign in_ready  = w_run && (w_count <= c_READY_MAX);
    assign w_accept  = in_ready && !init_req;

    assign w_rec1 = {br_pc1[IDX_W-1:0], br_taken1, br_target1};
    assign w_rec2 = {br_pc2[IDX_W-1:0], br_taken2, br_target2};

    // Compact the two slots so the older valid branch is always written first.
    assign w_rec_first = br_valid1 ? w_rec1 : w_rec2;
    assign w_push_a    = w_accept && (br_valid1 || br_valid2);
    assign w_push_b    = w_accept && br_valid1 && br_valid2;
    assign w_pop       = w_run && !init_req && (w_count != '0);

    bpu_upd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clear  (init_req),
        .push_a (w_push_a),
        .data_a (w_rec_first),
        .push_b (w_push_b),
        .data_b (w_rec2),
        .pop    (w_pop),
        .head   (w_head),
        .count  (w_count)
    );

    // Sweep FSM: walk every index once, then hand the port to the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_INIT;
            r_sweep <= '0;
        end else if (init_req) begin
            r_state <= c_ST_INIT;
            r_sweep <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_sweep <= r_sweep + IDX_W'(1);
            if (r_sweep == c_SWEEP_LAST) begin
                r_state <= c_ST_RUN;
            end
        end
    end

    // Registered update port: init writes during the sweep, queue head in run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_valid  <= 1'b0;
            upd_init   <= 1'b0;
            upd_index  <= '0;
            upd_taken  <= 1'b0;
            upd_target <= '0;
        end else if (init_req) begin
            upd_valid  <= 1'b0;
            upd_init   <= 1'b0;
        end else if (r_state == c_ST_INIT) begin
            upd_valid  <= 1'b1;
            upd_init   <= 1'b1;
            upd_index  <= r_sweep;
            upd_taken  <= 1'b0;
            upd_target <= '0;
        end else if (w_pop) begin
            upd_valid  <= 1'b1;
            upd_init   <= 1'b0;
            upd_index  <= w_head[REC_W-1 -: IDX_W];
            upd_taken  <= w_head[PC_W];
            upd_target <= w_head[PC_W-1:0];
        end else begin
            upd_valid  <= 1'b0;
            upd_init   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bpu_update_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bpu_update_scheduler
//  Purpose  : Self-checking bench for bpu_update_scheduler: init sweeps,
//             vector table of single-cycle branch pairs, back-pressure,
//             init_req discard and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bpu_update_scheduler;
    import bpu_pkg::*;

    localparam int PC_W    = BPU_PC_W;
    localparam int IDX_W   = BPU_IDX_W;
    localparam int DEPTH   = 4;
    localparam int ENTRIES = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             init_req = 1'b0;
    logic             br_valid1 = 1'b0;
    logic             br_valid2 = 1'b0;
    logic [PC_W-1:0]  br_pc1 = '0;
    logic [PC_W-1:0]  br_pc2 = '0;
    logic             br_taken1 = 1'b0;
    logic             br_taken2 = 1'b0;
    logic [PC_W-1:0]  br_target1 = '0;
    logic [PC_W-1:0]  br_target2 = '0;
    logic             in_ready;
    logic             init_done;
    logic             upd_valid;
    logic             upd_init;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_target;

    bpu_update_scheduler #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .init_req   (init_req),
        .br_valid1  (br_valid1),
        .br_valid2  (br_valid2),
        .br_pc1     (br_pc1),
        .br_pc2     (br_pc2),
        .br_taken1  (br_taken1),
        .br_taken2  (br_taken2),
        .br_target1 (br_target1),
        .br_target2 (br_target2),
        .in_ready   (in_ready),
        .init_done  (init_done),
        .upd_valid  (upd_valid),
        .upd_init   (upd_init),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            v1;
        logic [PC_W-1:0] pc1;
        logic            t1;
        logic [PC_W-1:0] tg1;
        logic            v2;
        logic [PC_W-1:0] pc2;
        logic            t2;
        logic [PC_W-1:0] tg2;
        int              n;
        bpu_upd_t        exp_a;
        bpu_upd_t        exp_b;
    } vec_t;

    int       total = 0;
    int       bad = 0;
    bpu_upd_t sb[$];
    bit       expect_init = 1'b0;
    vec_t     tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bpu_upd_t mk(input logic [PC_W-1:0] pc, input logic t, input logic [PC_W-1:0] tg);
        bpu_upd_t r;
        r.index  = pc[IDX_W-1:0];
        r.taken  = t;
        r.target = tg;
        return r;
    endfunction

    function automatic vec_t mkvec(input logic v1, input logic [PC_W-1:0] pc1, input logic t1,
                                   input logic [PC_W-1:0] tg1, input logic v2, input logic [PC_W-1:0] pc2,
                                   input logic t2, input logic [PC_W-1:0] tg2, input int n,
                                   input bpu_upd_t ea, input bpu_upd_t eb);
        vec_t v;
        v.v1 = v1; v.pc1 = pc1; v.t1 = t1; v.tg1 = tg1;
        v.v2 = v2; v.pc2 = pc2; v.t2 = t2; v.tg2 = tg2;
        v.n = n; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    function automatic bpu_upd_t rec(input logic [IDX_W-1:0] idx, input logic t, input logic [PC_W-1:0] tg);
        bpu_upd_t r;
        r.index  = idx;
        r.taken  = t;
        r.target = tg;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slots(input logic v1, input logic [PC_W-1:0] pc1, input logic t1, input logic [PC_W-1:0] tg1,
                             input logic v2, input logic [PC_W-1:0] pc2, input logic t2, input logic [PC_W-1:0] tg2);
        br_valid1 = v1; br_pc1 = pc1; br_taken1 = t1; br_target1 = tg1;
        br_valid2 = v2; br_pc2 = pc2; br_taken2 = t2; br_target2 = tg2;
    endtask

    task automatic set_idle();
        set_slots(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic wait_ready(input string name);
        for (int c = 0; c < 50 && !in_ready; c++) tick();
        check(name, 32'(in_ready), 32'd1);
    endtask

    // Expects the full init sweep starting at the next edge.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < ENTRIES; i++) begin
            tick();
            check({tag, "_init_valid"}, 32'(upd_valid), 32'd1);
            check({tag, "_init_flag"}, 32'(upd_init), 32'd1);
            check({tag, "_init_index"}, 32'(upd_index), 32'(i));
            check({tag, "_init_taken"}, 32'(upd_taken), 32'd0);
            check({tag, "_init_target"}, 32'(upd_target), 32'd0);
            check({tag, "_init_done"}, 32'(init_done), 32'(i == ENTRIES - 1));
            check({tag, "_in_ready"}, 32'(in_ready), 32'(i == ENTRIES - 1));
        end
        set_idle();
        tick();
        expect_init = 1'b0;
        check({tag, "_post_sweep_idle"}, 32'(upd_valid), 32'd0);
    endtask

    // Scoreboard side: every non-init write must match the oldest expected record.
    always @(posedge clk) begin
        bpu_upd_t e;
        #1;
        if (reset && upd_valid && !upd_init) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_update: got index %0h want no write", upd_index);
            end else begin
                e = sb.pop_front();
                check("upd_index", 32'(upd_index), 32'(e.index));
                check("upd_taken", 32'(upd_taken), 32'(e.taken));
                if (e.taken) check("upd_target", 32'(upd_target), 32'(e.target));
            end
        end
        if (reset && upd_valid && upd_init && !expect_init) begin
            total++;
            bad++;
            $display("FAIL unexpected_init: got index %0h want no init write", upd_index);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit saw_stall;
        vec_t v;

        tbl[0] = mkvec(1'b1, 11'h045, 1'b1, 11'h100, 1'b1, 11'h013, 1'b0, 11'h033, 2,
                       rec(5'd5, 1'b1, 11'h100), rec(5'd19, 1'b0, 11'h033));
        tbl[1] = mkvec(1'b0, 11'h155, 1'b1, 11'h3FF, 1'b1, 11'h7FF, 1'b1, 11'h002, 1,
                       rec(5'd31, 1'b1, 11'h002), rec(5'd0, 1'b0, 11'h000));
        tbl[2] = mkvec(1'b1, 11'h00A, 1'b1, 11'h050, 1'b1, 11'h02A, 1'b0, 11'h077, 2,
                       rec(5'd10, 1'b1, 11'h050), rec(5'd10, 1'b0, 11'h077));
        tbl[3] = mkvec(1'b1, 11'h3C1, 1'b0, 11'h1AB, 1'b0, 11'h222, 1'b1, 11'h444, 1,
                       rec(5'd1, 1'b0, 11'h1AB), rec(5'd0, 1'b0, 11'h000));

        // Reset state
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_upd_init", 32'(upd_init), 32'd0);
        check("rst_upd_index", 32'(upd_index), 32'd0);
        check("rst_upd_taken", 32'(upd_taken), 32'd0);
        check("rst_upd_target", 32'(upd_target), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Boot sweep
        reset = 1'b1;
        expect_init = 1'b1;
        sweep_check("boot");

        // Vector table: one cycle of stimulus each, then latency and drain
        for (int k = 0; k < 4; k++) begin
            wait_ready("tbl_ready");
            v = tbl[k];
            set_slots(v.v1, v.pc1, v.t1, v.tg1, v.v2, v.pc2, v.t2, v.tg2);
            sb.push_back(v.exp_a);
            if (v.n == 2) sb.push_back(v.exp_b);
            tick();
            set_idle();
            check("tbl_lat0", 32'(upd_valid), 32'd0);
            tick();
            check("tbl_lat1", 32'(upd_valid), 32'd1);
            tick();
            check("tbl_lat2", 32'(upd_valid), 32'(v.n == 2));
            tick();
            check("tbl_lat3", 32'(upd_valid), 32'd0);
        end
        check("tbl_drained", 32'(sb.size()), 32'd0);

        // Back-pressure: four pairs held until accepted
        saw_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_slots(1'b1, 11'(8 * k + 1), k[0], 11'(16 * k + 3),
                      1'b1, 11'(8 * k + 2), ~k[0], 11'(16 * k + 7));
            acc = 1'b0;
            for (int c = 0; c < 20 && !acc; c++) begin
                acc = in_ready;
                if (acc) begin
                    sb.push_back(mk(br_pc1, br_taken1, br_target1));
                    sb.push_back(mk(br_pc2, br_taken2, br_target2));
                end else begin
                    saw_stall = 1'b1;
                end
                tick();
            end
            check("bp_accept", 32'(acc), 32'd1);
        end
        set_idle();
        for (int c = 0; c < 40 && sb.size() != 0; c++) tick();
        check("bp_stall_seen", 32'(saw_stall), 32'd1);
        check("bp_drained", 32'(sb.size()), 32'd0);
        tick();
        check("bp_ready_after", 32'(in_ready), 32'd1);

        // init_req with three entries queued
        wait_ready("ireq_ready");
        set_slots(1'b1, 11'h061, 1'b1, 11'h111, 1'b1, 11'h062, 1'b0, 11'h122);
        sb.push_back(mk(br_pc1, br_taken1, br_target1));
        sb.push_back(mk(br_pc2, br_taken2, br_target2));
        tick();
        check("ireq_ready2", 32'(in_ready), 32'd1);
        set_slots(1'b1, 11'h063, 1'b1, 11'h133, 1'b1, 11'h064, 1'b1, 11'h144);
        sb.push_back(mk(br_pc1, br_taken1, br_target1));
        sb.push_back(mk(br_pc2, br_taken2, br_target2));
        tick();
        init_req = 1'b1;
        expect_init = 1'b1;
        set_slots(1'b1, 11'h065, 1'b1, 11'h155, 1'b1, 11'h066, 1'b1, 11'h166);
        tick();
        init_req = 1'b0;
        check("ireq_no_issue", 32'(upd_valid), 32'd0);
        check("ireq_init_done", 32'(init_done), 32'd0);
        sb.delete();
        sweep_check("ireq");
        repeat (3) tick();
        check("ireq_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset with data queued
        wait_ready("areset_ready");
        set_slots(1'b1, 11'h071, 1'b1, 11'h171, 1'b1, 11'h072, 1'b1, 11'h172);
        tick();
        set_idle();
        #2;
        reset = 1'b0;
        sb.delete();
        expect_init = 1'b1;
        #1;
        check("areset_valid", 32'(upd_valid), 32'd0);
        check("areset_init_done", 32'(init_done), 32'd0);
        check("areset_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b1;
        sweep_check("areset");
        repeat (3) tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
